// File: rtl/afe_spi_pkg.sv
// afe_spi_pkg: shared types and constants for the AFE4403 SPI arbiter.
// Holds the FSM state enum, default sizes and requester index names.
package afe_spi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int NREQ_DEFAULT           = 4;
    localparam int BYTES_PER_XFER_DEFAULT = 4;

    localparam int REQ_INI  = 0;
    localparam int REQ_BRT  = 1;
    localparam int REQ_DIAG = 2;
    localparam int REQ_ADC  = 3;

endpackage

// File: rtl/afe_spi_arbiter_if.sv
// afe_spi_arbiter_if: requester-side and SPI-master-side signal bundle.
// The arbiter connects through the slave modport, the stimulus side through master.
interface afe_spi_arbiter_if
    import afe_spi_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   rd_en_in;
    logic [NREQ-1:0]   wr_en_in;
    logic [8*NREQ-1:0] tx_data_in;
    logic              abort;
    logic              spi_done;
    logic [7:0]        spi_rx_data;

    logic [NREQ-1:0]   gnt;
    logic              spi_rd_en;
    logic              spi_wr_en;
    logic [7:0]        spi_tx_data;
    logic              spi_flag;
    logic [1:0]        data_part;
    logic              flash;
    logic [7:0]        rx_data;
    logic [NREQ-1:0]   rx_vld;
    logic [NREQ-1:0]   xfer_done;
    logic              timeout_err;

    modport master (
        output req, rd_en_in, wr_en_in, tx_data_in,
        output abort, spi_done, spi_rx_data,
        input  gnt, spi_rd_en, spi_wr_en, spi_tx_data, spi_flag,
        input  data_part, flash, rx_data, rx_vld, xfer_done, timeout_err
    );

    modport slave (
        input  req, rd_en_in, wr_en_in, tx_data_in,
        input  abort, spi_done, spi_rx_data,
        output gnt, spi_rd_en, spi_wr_en, spi_tx_data, spi_flag,
        output data_part, flash, rx_data, rx_vld, xfer_done, timeout_err
    );

endinterface

// File: rtl/afe_spi_arbiter_prio.sv
// spi_arb_prio: combinational fixed-priority encoder, lowest index wins.
// Isolates the lowest set request bit as a one-hot winner.
module spi_arb_prio #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] win
);

    // two's-complement trick keeps only the lowest set bit
    assign win = req & (~req + 1'b1);

endmodule

// File: rtl/afe_spi_arbiter.sv
// afe_spi_arbiter: fixed-priority owner of the shared AFE4403 SPI master.
// Optional inter-byte watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module afe_spi_arbiter
    import afe_spi_pkg::*;
#(
    parameter int NREQ           = NREQ_DEFAULT,
    parameter int BYTES_PER_XFER = BYTES_PER_XFER_DEFAULT
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC    = 1024
`endif
) (
    input logic               div_clk,
    input logic               rst,
    afe_spi_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = ARB_IDLE;
    localparam logic [1:0] ST_XFER   = ARB_XFER;
    localparam logic [1:0] ST_DONE   = ARB_DONE;
    localparam logic [1:0] LAST_PART = 2'(BYTES_PER_XFER - 1);

    logic [1:0]      state_q;
    logic [NREQ-1:0] gnt_q;
    logic [1:0]      part_q;
    logic            flash_q;
    logic [7:0]      rx_q;
    logic [NREQ-1:0] rx_vld_q;
    logic [NREQ-1:0] xdone_q;

    logic [NREQ-1:0] win;
    logic            wd_hit;
    logic            kill;

    logic            rd_mux;
    logic            wr_mux;
    logic [7:0]      tx_mux;

    spi_arb_prio #(
        .NREQ (NREQ)
    ) u_prio (
        .req (bus.req),
        .win (win)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC);

    logic [WDW-1:0] wd_q;
    logic           to_q;

    assign wd_hit = (state_q == ST_XFER)
                  && (wd_q == WDW'(TIMEOUT_CYC - 1));

    // idle-cycle counter: restarts on each byte and outside XFER
    always_ff @(posedge div_clk) begin
        if (rst || kill || state_q != ST_XFER || bus.spi_done)
            wd_q <= '0;
        else
            wd_q <= wd_q + 1'b1;
    end

    // one-cycle error pulse coincides with the forced return to IDLE
    always_ff @(posedge div_clk) begin
        if (rst)
            to_q <= 1'b0;
        else
            to_q <= wd_hit;
    end

    assign bus.timeout_err = to_q;
`else
    assign wd_hit          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign kill = bus.abort | wd_hit;

    // grant, byte index and per-byte/per-access pulses
    always_ff @(posedge div_clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            part_q   <= '0;
            flash_q  <= 1'b0;
            rx_q     <= '0;
            rx_vld_q <= '0;
            xdone_q  <= '0;
        end else begin
            flash_q  <= 1'b0;
            rx_vld_q <= '0;
            xdone_q  <= '0;
            if (kill) begin
                state_q <= ST_IDLE;
                gnt_q   <= '0;
                part_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (|bus.req) begin
                            gnt_q   <= win;
                            state_q <= ST_XFER;
                        end
                    end
                    ST_XFER: begin
                        if (bus.spi_done) begin
                            flash_q  <= 1'b1;
                            rx_q     <= bus.spi_rx_data;
                            rx_vld_q <= gnt_q;
                            if (part_q == LAST_PART) begin
                                part_q  <= '0;
                                xdone_q <= gnt_q;
                                gnt_q   <= '0;
                                state_q <= ST_DONE;
                            end else begin
                                part_q <= part_q + 2'd1;
                            end
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // AND-OR mux of the granted requester onto the SPI master
    always_comb begin
        rd_mux = 1'b0;
        wr_mux = 1'b0;
        tx_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd_mux = rd_mux | (gnt_q[i] & bus.rd_en_in[i]);
            wr_mux = wr_mux | (gnt_q[i] & bus.wr_en_in[i]);
            tx_mux = tx_mux | ({8{gnt_q[i]}} & bus.tx_data_in[8*i +: 8]);
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.spi_rd_en   = rd_mux;
    assign bus.spi_wr_en   = wr_mux;
    assign bus.spi_tx_data = tx_mux;
    assign bus.spi_flag    = (state_q == ST_XFER);
    assign bus.data_part   = part_q;
    assign bus.flash       = flash_q;
    assign bus.rx_data     = rx_q;
    assign bus.rx_vld      = rx_vld_q;
    assign bus.xfer_done   = xdone_q;

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// tb_afe_spi_arbiter: directed scenarios plus randomized traffic for afe_spi_arbiter.
// Define SPI_ARB_TIMEOUT_EN to build and exercise the watchdog with TIMEOUT_CYC=16.
module tb_afe_spi_arbiter;
    import afe_spi_pkg::*;

    localparam int N   = 4;
    localparam int BPX = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    afe_spi_arbiter_if #(.NREQ(N)) bus ();

`ifdef SPI_ARB_TIMEOUT_EN
    afe_spi_arbiter #(
        .NREQ(N), .BYTES_PER_XFER(BPX), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .div_clk(clk), .rst(rst), .bus(bus.slave)
    );
`else
    afe_spi_arbiter #(
        .NREQ(N), .BYTES_PER_XFER(BPX)
    ) dut (
        .div_clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    int checks = 0;
    int errors = 0;

    // reference: who owns the bus, bytes moved, idle cycles, cool-down flag
    int         m_owner = -1;
    int         m_bytes = 0;
    int         m_idle  = 0;
    bit         m_done  = 1'b0;
    logic [N-1:0] e_gnt, e_rxvld, e_xd;
    logic [1:0]   e_dp;
    logic         e_flash, e_to;
    logic [7:0]   e_rxd;

    task automatic model_step();
        bit hit;
        e_flash = 1'b0;
        e_rxvld = '0;
        e_xd    = '0;
        e_to    = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_bytes = 0;
            m_idle  = 0;
            m_done  = 1'b0;
            e_rxd   = 8'h00;
        end else begin
            hit = (TO_CYC > 0) && (m_owner >= 0) && (m_idle == TO_CYC - 1);
            if (bus.abort || hit) begin
                m_owner = -1;
                m_bytes = 0;
                m_idle  = 0;
                m_done  = 1'b0;
                e_to    = hit;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_owner < 0) begin
                for (int i = N - 1; i >= 0; i--)
                    if (bus.req[i]) m_owner = i;
                m_idle = 0;
            end else if (bus.spi_done) begin
                e_flash = 1'b1;
                e_rxd   = bus.spi_rx_data;
                e_rxvld = N'(1 << m_owner);
                m_bytes = m_bytes + 1;
                m_idle  = 0;
                if (m_bytes == BPX) begin
                    e_xd    = N'(1 << m_owner);
                    m_owner = -1;
                    m_bytes = 0;
                    m_done  = 1'b1;
                end
            end else begin
                m_idle = m_idle + 1;
            end
        end
        e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_dp  = 2'(m_bytes % 4);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req         = '0;
        bus.rd_en_in    = '0;
        bus.wr_en_in    = '0;
        bus.tx_data_in  = '0;
        bus.abort       = 1'b0;
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req = 4'b1111;
        rst = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.spi_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", bus.spi_flag); end
        checks++; if (bus.data_part !== 2'd0) begin errors++; $display("FAIL reset_dp got=%0d exp=0", bus.data_part); end
        checks++; if ({bus.flash, bus.rx_vld, bus.xfer_done, bus.timeout_err} !== 10'd0) begin
            errors++; $display("FAIL reset_pulses got=%b exp=0", {bus.flash, bus.rx_vld, bus.xfer_done, bus.timeout_err});
        end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx got=%h exp=00", bus.rx_data); end
        bus.req = '0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        logic [7:0] b;
        bus.req = 4'b1000;
        cyc();
        bus.req = '0;
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL single_gnt got=%b exp=1000", bus.gnt); end
        checks++; if (bus.spi_flag !== 1'b1) begin errors++; $display("FAIL single_flag got=%b exp=1", bus.spi_flag); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++; if (bus.flash !== 1'b0) begin errors++; $display("FAIL single_gap_flash k=%0d got=%b exp=0", k, bus.flash); end
            b = 8'((k + 1) * 8'h11);
            bus.spi_done = 1'b1;
            bus.spi_rx_data = b;
            cyc();
            bus.spi_done = 1'b0;
            checks++; if (bus.rx_vld !== 4'b1000 || bus.rx_data !== b || bus.flash !== 1'b1) begin
                errors++; $display("FAIL single_byte k=%0d vld=%b rx=%h flash=%b exp vld=1000 rx=%h flash=1", k, bus.rx_vld, bus.rx_data, bus.flash, b);
            end
            checks++; if (bus.data_part !== 2'((k + 1) % 4)) begin
                errors++; $display("FAIL single_dp k=%0d got=%0d exp=%0d", k, bus.data_part, (k + 1) % 4);
            end
            checks++; if (bus.xfer_done !== ((k == 3) ? 4'b1000 : 4'b0000)) begin
                errors++; $display("FAIL single_xd k=%0d got=%b", k, bus.xfer_done);
            end
        end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_done_gnt got=%b exp=0000", bus.gnt); end
        cyc();
        checks++; if (bus.xfer_done !== 4'b0000 || bus.rx_vld !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_width xd=%b vld=%b exp=0", bus.xfer_done, bus.rx_vld);
        end
    endtask

    task automatic test_priority();
        bus.req = 4'b1010;
        cyc();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL prio_gnt got=%b exp=0010", bus.gnt); end
        bus.req = 4'b1000;
        bus.spi_done = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        bus.spi_done = 1'b0;
        checks++; if (bus.gnt !== 4'b0000 || bus.xfer_done !== 4'b0010) begin
            errors++; $display("FAIL prio_done gnt=%b xd=%b exp gnt=0000 xd=0010", bus.gnt, bus.xfer_done);
        end
        cyc();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL prio_idle_gnt got=%b exp=0000", bus.gnt); end
        cyc();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL prio_next_gnt got=%b exp=1000", bus.gnt); end
        bus.req = '0;
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL prio_abort_gnt got=%b exp=0000", bus.gnt); end
    endtask

    task automatic test_no_preempt();
        bus.req = 4'b1000;
        cyc();
        for (int k = 0; k < 2; k++) begin
            bus.spi_done = 1'b1; cyc();
            bus.spi_done = 1'b0; cyc();
        end
        bus.req = 4'b0100;
        cyc();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL nopre_hold got=%b exp=1000", bus.gnt); end
        for (int k = 0; k < 2; k++) begin
            bus.spi_done = 1'b1; cyc();
            bus.spi_done = 1'b0;
            if (k == 0) cyc();
        end
        checks++; if (bus.xfer_done !== 4'b1000 || bus.gnt !== 4'b0000) begin
            errors++; $display("FAIL nopre_done xd=%b gnt=%b exp xd=1000 gnt=0000", bus.xfer_done, bus.gnt);
        end
        cyc();
        cyc();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL nopre_next got=%b exp=0100", bus.gnt); end
        bus.req = '0;
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
    endtask

    task automatic test_abort_final();
        bus.req = 4'b0001;
        cyc();
        bus.req = '0;
        for (int k = 0; k < 3; k++) begin
            bus.spi_done = 1'b1; cyc();
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        bus.spi_done = 1'b0;
        checks++; if (bus.xfer_done !== 4'b0000 || bus.rx_vld !== 4'b0000 || bus.flash !== 1'b0) begin
            errors++; $display("FAIL abort_pulses xd=%b vld=%b flash=%b exp=0", bus.xfer_done, bus.rx_vld, bus.flash);
        end
        checks++; if (bus.data_part !== 2'd0 || bus.gnt !== 4'b0000 || bus.spi_flag !== 1'b0) begin
            errors++; $display("FAIL abort_state dp=%0d gnt=%b flag=%b exp 0", bus.data_part, bus.gnt, bus.spi_flag);
        end
        cyc();
        checks++; if (bus.xfer_done !== 4'b0000) begin errors++; $display("FAIL abort_late_xd got=%b exp=0000", bus.xfer_done); end
    endtask

    task automatic test_mux();
        bus.rd_en_in   = 4'b0100;
        bus.wr_en_in   = 4'b1011;
        bus.tx_data_in = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        bus.req = 4'b0100;
        cyc();
        bus.req = '0;
        checks++; if (bus.spi_rd_en !== 1'b1 || bus.spi_wr_en !== 1'b0 || bus.spi_tx_data !== 8'hA5) begin
            errors++; $display("FAIL mux_sel rd=%b wr=%b tx=%h exp rd=1 wr=0 tx=a5", bus.spi_rd_en, bus.spi_wr_en, bus.spi_tx_data);
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        checks++; if (bus.spi_rd_en !== 1'b0 || bus.spi_wr_en !== 1'b0 || bus.spi_tx_data !== 8'h00) begin
            errors++; $display("FAIL mux_free rd=%b wr=%b tx=%h exp 0", bus.spi_rd_en, bus.spi_wr_en, bus.spi_tx_data);
        end
        idle_inputs();
        cyc();
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        seen = 0;
        bus.req = 4'b0010;
        cyc();
        bus.req = '0;
        for (int k = 1; k <= 40 && seen == 0; k++) begin
            cyc();
            if (bus.timeout_err === 1'b1) seen = k;
        end
        checks++; if (seen != TO_CYC) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", seen, TO_CYC); end
        checks++; if (bus.gnt !== 4'b0000 || bus.spi_flag !== 1'b0 || bus.xfer_done !== 4'b0000) begin
            errors++; $display("FAIL to_state gnt=%b flag=%b xd=%b exp 0", bus.gnt, bus.spi_flag, bus.xfer_done);
        end
        cyc();
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_width got=%b exp=0", bus.timeout_err); end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] r;
        logic e_rd, e_wr;
        logic [7:0] e_tx;
        logic [63:0] got, exp;
        for (int c = 0; c < 1500; c++) begin
            r = 4'($urandom_range(0, 15));
            bus.req         = ($urandom_range(0, 3) == 0) ? '0 : r;
            bus.rd_en_in    = 4'($urandom);
            bus.wr_en_in    = 4'($urandom);
            bus.tx_data_in  = 32'($urandom);
            bus.spi_done    = ($urandom_range(0, 2) == 0);
            bus.spi_rx_data = 8'($urandom);
            bus.abort       = ($urandom_range(0, 59) == 0);
            cyc();
            e_rd = (m_owner >= 0) ? bus.rd_en_in[m_owner] : 1'b0;
            e_wr = (m_owner >= 0) ? bus.wr_en_in[m_owner] : 1'b0;
            e_tx = (m_owner >= 0) ? bus.tx_data_in[8*m_owner +: 8] : 8'h00;
            got = 64'({bus.gnt, bus.data_part, bus.flash, bus.rx_vld, bus.xfer_done,
                       bus.rx_data, bus.timeout_err, bus.spi_flag,
                       bus.spi_rd_en, bus.spi_wr_en, bus.spi_tx_data});
            exp = 64'({e_gnt, e_dp, e_flash, e_rxvld, e_xd,
                       e_rxd, e_to, (m_owner >= 0),
                       e_rd, e_wr, e_tx});
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand c=%0d got=%h exp=%h", c, got, exp);
            end
        end
        idle_inputs();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_abort_final();
        test_mux();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/afe_spi_arbiter.md
# afe_spi_arbiter

Fixed-priority arbiter and transaction sequencer sharing the single AFE4403 SPI master among the init, brightness-adjust, diagnostic and ADC-readout requesters. It grants the bus to one requester for a whole register access. That access is BYTES_PER_XFER byte strobes from the SPI master. While the grant is held, the block:
- muxes the granted requester's enables and transmit byte onto the master,
- steers received bytes back to the granted requester,
- generates the shared `data_part` byte index and `flash` strobe.

It sits between the requester FSMs and the SPI master, replacing ad-hoc enable muxing.

## Interface
- NREQ, 4, number of requesters; index 0 is highest priority.
- BYTES_PER_XFER, 4, SPI byte strobes per register access (address plus 3 data bytes).
- TIMEOUT_CYC, 1024, maximum cycles allowed between byte strobes (used only with the macro).

Ports:
- div_clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester access request, level.
- rd_en_in  in  NREQ  per-requester read enable.
- wr_en_in  in  NREQ  per-requester write enable.
- tx_data_in  in  8*NREQ  per-requester transmit byte; requester i uses bits [8i+7:8i].
- abort  in  1  one-cycle abort, e.g. a brightness or diagnostic restart.
- spi_done  in  1  one-cycle byte-complete strobe from the SPI master.
- spi_rx_data  in  8  received byte from the SPI master.
- gnt  out  NREQ  one-hot grant; all zero when the bus is free.
- spi_rd_en  out  1  muxed read enable to the SPI master.
- spi_wr_en  out  1  muxed write enable to the SPI master.
- spi_tx_data  out  8  muxed transmit byte to the SPI master.
- spi_flag  out  1  bus-active flag to the SPI master.
- data_part  out  2  byte index within the current access.
- flash  out  1  byte-advance strobe.
- rx_data  out  8  registered received byte.
- rx_vld  out  NREQ  one-hot "rx_data valid" pulse for the granted requester.
- xfer_done  out  NREQ  one-hot end-of-access pulse.
- timeout_err  out  1  watchdog error pulse.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any `req` is high, the lowest set index wins.
  - `gnt` is registered one-hot on the next edge and the FSM enters XFER.
  - `spi_done` seen in IDLE or DONE is ignored.
- XFER:
  - `spi_rd_en`, `spi_wr_en` and `spi_tx_data` are the AND-OR mux of the requester inputs selected by `gnt`; all are zero when `gnt` is 0.
  - `spi_flag` is 1.
  - On each `spi_done`:
    - `data_part` increments, modulo 4.
    - `flash` pulses.
    - `rx_data` captures `spi_rx_data`.
    - `rx_vld` pulses for the granted index.
  - On the `spi_done` where `data_part` == BYTES_PER_XFER-1:
    - `data_part` wraps to 0.
    - `xfer_done` pulses for the granted index.
    - `gnt` clears.
    - The FSM enters DONE.
- DONE: lasts one cycle, then IDLE and re-arbitration. A requester wanting another access keeps `req` high.
- Dropping `req` mid-XFER is ignored; the grant is held until the access completes or is aborted.
- Fixed priority applies; lower requesters may starve while higher ones re-request. This is accepted because init and brightness-adjust traffic is bounded.
- `abort`, in any state:
  - Next edge: IDLE, `gnt` 0, `data_part` 0, `flash`/`rx_vld`/`xfer_done` 0.
  - `abort` has priority over a simultaneous `spi_done`, including the final one; no `xfer_done` is issued.
- Reset values: all outputs 0; FSM in IDLE.

## Timing
- `req` high in IDLE at edge n → `gnt` and `spi_flag` valid after edge n+1.
- `spi_done` at cycle m → `data_part`, `flash`, `rx_data`, `rx_vld` updated after edge m+1.
- Final byte at cycle m:
  - `xfer_done` high and `gnt` 0 during cycle m+1 (DONE).
  - IDLE in cycle m+2.
  - Earliest next `gnt` in cycle m+3.
- `flash`, `rx_vld`, `xfer_done` and `timeout_err` are exactly one cycle wide.
- The muxed SPI outputs are combinational from `gnt` and the requester inputs; there is no added latency.

## Configuration
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to XFER and on each `spi_done`, and increments otherwise while in XFER.
  - At TIMEOUT_CYC-1, the block behaves as `abort` and `timeout_err` pulses for one cycle.
- Undefined: no counter; `timeout_err` is tied to 0.

## Structure
- Package `afe_spi_pkg`:
  - FSM state enum.
  - NREQ and BYTES_PER_XFER defaults.
  - Index constants REQ_INI=0, REQ_BRT=1, REQ_DIAG=2, REQ_ADC=3.
- Sub-module `spi_arb_prio`: combinational fixed-priority encoder, `req` → one-hot winner.
- The watchdog stays inline under the macro.

## Test plan
- req=4'b1000, four spaced `spi_done` strobes with rx bytes 0x11/0x22/0x33/0x44 → gnt=4'b1000; rx_vld[3] pulses ×4 with matching rx_data; data_part 1,2,3,0; xfer_done[3] after the 4th strobe.
- req=4'b1010 in IDLE → gnt=4'b0010; req[3] is served only after that access's DONE cycle.
- req[2] raised in the middle of a requester-3 access → no preemption; gnt moves to requester 2 in cycle m+3 after requester 3's final strobe.
- `abort` together with the 4th `spi_done` → xfer_done stays 0; data_part=0; gnt=0 next cycle.
- rd_en_in=4'b0100, tx_data_in[23:16]=0xA5, gnt=4'b0100 → spi_rd_en=1, spi_tx_data=0xA5; when gnt=0 all three muxed outputs are 0.
- With SPI_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=16, grant and then withhold `spi_done` → timeout_err pulses after 16 cycles in XFER; FSM returns to IDLE; no xfer_done.
